// File: rtl/pipelined_adder_n.sv
// Pipelined ripple-carry adder: WIDTH bits split into STAGES registered ripple slices with a valid/ready handshake.
// Optional macro PIPELINED_ADDER_SUB_EN adds a per-vector SUB input (A - B - borrow).
module pipelined_adder_n #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef PIPELINED_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int W = WIDTH / STAGES;

    // Result of one slice: running sum, carry out of the slice, and carry into bit WIDTH-1.
    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             cmsb;
    } slice_t;

    // Ripple chain over slice s; bits below the slice come from the registered lower partial sum.
    function automatic slice_t add_slice(input logic [WIDTH-1:0] x,
                                         input logic [WIDTH-1:0] y,
                                         input logic [WIDTH-1:0] lower,
                                         input logic             cin,
                                         input int               s);
        slice_t r;
        logic   c;
        logic   h;
        int     k;
        r.sum  = lower;
        r.cmsb = 1'b0;
        c      = cin;
        for (int i = 0; i < W; i++) begin
            k        = s * W + i;
            h        = x[k] ^ y[k];
            r.sum[k] = h ^ c;
            if (k == WIDTH - 1) r.cmsb = c;
            c        = (x[k] & y[k]) | (h & c);
        end
        r.cout = c;
        return r;
    endfunction

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

`ifdef PIPELINED_ADDER_SUB_EN
    // Subtraction is folded into the operands at entry, so the inverted B riding the skew
    // registers carries each vector's mode down the pipeline.
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = c_in ^ sub;
`else
    assign b_eff   = b;
    assign cin_eff = c_in;
`endif

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] cy_q;
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic              ovf_q;
    slice_t            nxt   [STAGES];

    // The whole pipeline advances together; a stalled output freezes every stage.
    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    if (STAGES == 1) begin : g_flat
        always_comb nxt[0] = add_slice(a, b_eff, '0, cin_eff, 0);
    end else begin : g_pipe
        logic [WIDTH-1:0] a_q [STAGES-1];
        logic [WIDTH-1:0] b_q [STAGES-1];

        // Operand skew: upper slices wait here until their turn in the ripple.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s < STAGES - 1; s++) begin
                    a_q[s] <= '0;
                    b_q[s] <= '0;
                end
            end else if (en) begin
                a_q[0] <= a;
                b_q[0] <= b_eff;
                for (int s = 1; s < STAGES - 1; s++) begin
                    a_q[s] <= a_q[s-1];
                    b_q[s] <= b_q[s-1];
                end
            end
        end

        always_comb begin
            nxt[0] = add_slice(a, b_eff, '0, cin_eff, 0);
            for (int s = 1; s < STAGES; s++) begin
                nxt[s] = add_slice(a_q[s-1], b_q[s-1], sum_q[s-1], cy_q[s-1], s);
            end
        end
    end

    // NOTE: non-blocking assignments let every stage sample its predecessor's old value,
    // and these small register arrays are reset explicitly because SUM must read 0 in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            cy_q  <= '0;
            ovf_q <= 1'b0;
            for (int s = 0; s < STAGES; s++) sum_q[s] <= '0;
        end else if (en) begin
            vld_q[0] <= in_valid;
            sum_q[0] <= nxt[0].sum;
            cy_q[0]  <= nxt[0].cout;
            for (int s = 1; s < STAGES; s++) begin
                vld_q[s] <= vld_q[s-1];
                sum_q[s] <= nxt[s].sum;
                cy_q[s]  <= nxt[s].cout;
            end
            ovf_q <= nxt[STAGES-1].cout ^ nxt[STAGES-1].cmsb;
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign c_out     = cy_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_adder_n.sv
// Self-checking bench for pipelined_adder_n: directed corner cases on a 64/4 instance plus
// randomized scoreboards on 64/1, 32/8 and 16/16 instances.
`timescale 1ns/1ps
module tb_pipelined_adder_n;

    localparam int WIDTH  = 64;
    localparam int STAGES = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             in_valid, in_ready, out_valid, out_ready;
    logic [WIDTH-1:0] a, b, sum;
    logic             c_in, c_out, ovf, sub;

    logic        sw_in_valid, sw_out_ready, sw_cin, sw_sub;
    logic [63:0] sw_a, sw_b;

    int n_vectors = 0;
    int n_miscompares = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit values; returns {ovf, c_out, sum}.
    function automatic logic [65:0] ref_add(input int w, input logic [63:0] va, input logic [63:0] vb,
                                            input logic vc, input logic vs);
        logic [63:0] m, x, y, s;
        logic [64:0] full;
        logic        co, ov;
        m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        x = va & m;
        y = vb & m;
        if (!vs) begin
            full = {1'b0, x} + {1'b0, y} + 65'(vc);
            s    = full[63:0] & m;
            co   = full[w];
            ov   = (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
        end else begin
            s  = (x - y - 64'(vc)) & m;
            co = !({1'b0, x} < ({1'b0, y} + 65'(vc)));
            ov = (x[w-1] != y[w-1]) && (s[w-1] != x[w-1]);
        end
        return {ov, co, s};
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0:       return '1;
            1:       return '0;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    pipelined_adder_n #(.WIDTH(WIDTH), .STAGES(STAGES)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
`ifdef PIPELINED_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    // Main scoreboard, sampled mid-cycle for the transfers of the coming rising edge.
    logic [65:0] m_sb [$];
    logic        stall_prev = 1'b0;
    logic [63:0] held_sum;
    logic [1:0]  held_flags;
    logic [65:0] m_exp;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sb.delete();
            stall_prev = 1'b0;
        end else begin
            check("in_ready_rule", in_ready, out_ready || !out_valid);
            if (stall_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_sum", sum, held_sum);
                check("hold_flags", {c_out, ovf}, held_flags);
            end
            if (out_valid && out_ready) begin
                if (m_sb.size() == 0) check("spurious_out", 1, 0);
                else begin
                    m_exp = m_sb.pop_front();
                    check("sum", sum, m_exp[63:0]);
                    check("c_out", c_out, m_exp[64]);
                    check("ovf", ovf, m_exp[65]);
                end
            end
            if (in_valid && in_ready) m_sb.push_back(ref_add(WIDTH, a, b, c_in, sub));
            stall_prev = out_valid && !out_ready;
            held_sum   = sum;
            held_flags = {c_out, ovf};
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int SW_W = (g == 0) ? 64 : (g == 1) ? 32 : 16;
        localparam int SW_S = (g == 0) ? 1 : (g == 1) ? 8 : 16;

        logic            s_in_ready, s_out_valid, s_c_out, s_ovf;
        logic [SW_W-1:0] s_sum;
        logic [65:0]     sb [$];
        logic [65:0]     e;

        pipelined_adder_n #(.WIDTH(SW_W), .STAGES(SW_S)) u_sw (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (sw_in_valid),
            .in_ready  (s_in_ready),
            .a         (sw_a[SW_W-1:0]),
            .b         (sw_b[SW_W-1:0]),
            .c_in      (sw_cin),
`ifdef PIPELINED_ADDER_SUB_EN
            .sub       (sw_sub),
`endif
            .out_valid (s_out_valid),
            .out_ready (sw_out_ready),
            .sum       (s_sum),
            .c_out     (s_c_out),
            .ovf       (s_ovf)
        );

        always @(negedge clk or negedge rst_n) begin
            if (!rst_n) sb.delete();
            else begin
                if (s_out_valid && sw_out_ready) begin
                    if (sb.size() == 0) check($sformatf("sw%0d_spurious", g), 1, 0);
                    else begin
                        e = sb.pop_front();
                        check($sformatf("sw%0d_sum", g), 64'(s_sum), e[63:0]);
                        check($sformatf("sw%0d_c_out", g), s_c_out, e[64]);
                        check($sformatf("sw%0d_ovf", g), s_ovf, e[65]);
                    end
                end
                if (sw_in_valid && s_in_ready) sb.push_back(ref_add(SW_W, sw_a, sw_b, sw_cin, sw_sub));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One vector into an idle pipeline; checks exact latency and the result.
    task automatic run_directed(input string tag, input logic [63:0] va, input logic [63:0] vb,
                                input logic vc, input logic vs,
                                input logic [63:0] es, input logic ec, input logic eo);
        a = va; b = vb; c_in = vc; sub = vs;
        in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < STAGES - 1; k++) begin
            check({tag, "_early"}, out_valid, 0);
            tick();
        end
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_sum"}, sum, es);
        check({tag, "_c_out"}, c_out, ec);
        check({tag, "_ovf"}, ovf, eo);
        tick();
        check({tag, "_gone"}, out_valid, 0);
    endtask

    logic [63:0] va [8];
    logic [63:0] vb [8];
    logic        vc [8];
    int          idx, cyc;
    logic        acc;

    initial begin
        in_valid = 0; out_ready = 1; a = '0; b = '0; c_in = 0; sub = 0;
        sw_in_valid = 0; sw_out_ready = 1; sw_a = '0; sw_b = '0; sw_cin = 0; sw_sub = 0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_flags", {c_out, ovf}, 0);
        check("rst_in_ready", in_ready, 1);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        run_directed("ripple", '1, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        run_directed("ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
`ifdef PIPELINED_ADDER_SUB_EN
        run_directed("sub", 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
`endif

        // Full-rate stream with three cycles of output backpressure in the middle.
        for (int i = 0; i < 8; i++) begin
            va[i] = pick(); vb[i] = pick(); vc[i] = 1'($urandom_range(0, 1));
        end
        idx = 0; cyc = 0;
        while (idx < 8 && cyc < 40) begin
            out_ready = !(cyc >= 5 && cyc <= 7);
            in_valid = 1'b1; a = va[idx]; b = vb[idx]; c_in = vc[idx];
            #1;
            if (!out_ready) check("bp_in_ready", in_ready, 0);
            acc = in_ready;
            @(posedge clk);
            #2;
            if (acc) idx++;
            cyc++;
        end
        check("bp_accepted", idx, 8);
        in_valid = 0; out_ready = 1;
        repeat (STAGES + 2) tick();
        check("bp_drained", m_sb.size(), 0);

        // Reset with results in flight.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; a = pick(); b = pick(); c_in = 1'($urandom_range(0, 1));
            tick();
        end
        check("rst_mid_pre_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_sum", sum, 0);
        check("rst_mid_flags", {c_out, ovf}, 0);
        check("rst_mid_in_ready", in_ready, 1);
        in_valid = 0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rst_post_idle", out_valid, 0);
        end
        run_directed("post_rst", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, '0, 1'b1, 1'b1);

        // Random traffic with bubbles and backpressure on every instance.
        for (int i = 0; i < 1400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a = pick(); b = pick(); c_in = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            sw_in_valid  = ($urandom_range(0, 4) != 0);
            sw_a = pick(); sw_b = pick(); sw_cin = 1'($urandom_range(0, 1));
            sw_out_ready = ($urandom_range(0, 4) != 0);
`ifdef PIPELINED_ADDER_SUB_EN
            sub    = 1'($urandom_range(0, 1));
            sw_sub = 1'($urandom_range(0, 1));
`endif
            tick();
        end
        in_valid = 0; sw_in_valid = 0; out_ready = 1; sw_out_ready = 1;
        repeat (24) tick();
        check("drain_main", m_sb.size(), 0);
        check("drain_64x1", g_sw[0].sb.size(), 0);
        check("drain_32x8", g_sw[1].sb.size(), 0);
        check("drain_16x16", g_sw[2].sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
